// File: rtl/eth_axi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_axi_pkg
// Description : Shared AXI burst type, response codes and mem2axi FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_bus.sv
`default_nettype none
// ============================================================================
// Module      : AXI_BUS
// Description : AXI4 bus bundle with Master/Slave modports.
// Revision    : 1.0 - initial release
// ============================================================================
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_USER_WIDTH = 10
);
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface
`default_nettype wire

// File: rtl/eth_mem2axi.sv
`default_nettype none
// ============================================================================
// Module      : eth_mem2axi
// Description : Single-beat req/gnt memory port to AXI4 master bridge, one
//               transaction in flight. ETH_MEM2AXI_POSTED_WRITE_EN enables
//               posted writes (gnt after AW/W, B collected in background).
// Revision    : 1.0 - initial release
// ============================================================================
module eth_mem2axi
    import eth_axi_pkg::*;
#(
    parameter int AXI_ID_WIDTH   = 10,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_USER_WIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    AXI_BUS.Master                      master,
    input  logic                        req_i,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    output logic                        gnt_o,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   data_o,
    output logic                        err_o
);

    localparam int LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH/8);

    state_t                        r_state;
    logic [AXI_ADDR_WIDTH-1:0]     r_addr;
    logic [AXI_DATA_WIDTH/8-1:0]   r_be;
    logic [AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [AXI_DATA_WIDTH-1:0]     r_rdata;
    logic                          r_arvalid;
    logic                          r_rready;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic                          r_aw_done;
    logic                          r_w_done;
    logic                          r_gnt;
    logic                          r_rvalid;
    logic                          r_err;
    logic                          w_aw_done;
    logic                          w_w_done;
    logic                          w_start;
    logic [AXI_ADDR_WIDTH-1:0]     w_axi_addr;

    assign w_aw_done  = r_aw_done | (r_awvalid & master.aw_ready);
    assign w_w_done   = r_w_done  | (r_wvalid  & master.w_ready);
    assign w_axi_addr = {r_addr[AXI_ADDR_WIDTH-1:LOG_NR_BYTES], {LOG_NR_BYTES{1'b0}}};

`ifdef ETH_MEM2AXI_POSTED_WRITE_EN
    logic r_b_pending;
    // New transactions wait until the outstanding posted B has been collected.
    assign w_start = req_i & ~r_b_pending;
`else
    assign w_start = req_i;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_gnt     <= 1'b0;
            r_rvalid  <= 1'b0;
            r_err     <= 1'b0;
`ifdef ETH_MEM2AXI_POSTED_WRITE_EN
            r_b_pending <= 1'b0;
`endif
        end else begin
            r_gnt    <= 1'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_addr  <= addr_i;
                        r_be    <= be_i;
                        r_wdata <= data_i;
                        if (we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= ST_AW_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (master.ar_ready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (master.r_valid) begin
                        r_rready <= 1'b0;
                        r_rdata  <= master.r_data;
                        r_err    <= (master.r_resp != RESP_OKAY);
                        r_gnt    <= 1'b1;
                        r_rvalid <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_AW_W: begin
                    if (w_aw_done) r_awvalid <= 1'b0;
                    if (w_w_done)  r_wvalid  <= 1'b0;
                    r_aw_done <= w_aw_done;
                    r_w_done  <= w_w_done;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
`ifdef ETH_MEM2AXI_POSTED_WRITE_EN
                        r_b_pending <= 1'b1;
                        r_gnt       <= 1'b1;
                        r_state     <= ST_DONE;
`else
                        r_state     <= ST_B;
`endif
                    end
                end
                ST_B: begin
                    if (master.b_valid) begin
                        r_bready <= 1'b0;
                        r_err    <= (master.b_resp != RESP_OKAY);
                        r_gnt    <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef ETH_MEM2AXI_POSTED_WRITE_EN
            // Posted B can land in any state; its error shows as a lone err_o pulse.
            if (r_b_pending && master.b_valid) begin
                r_b_pending <= 1'b0;
                r_bready    <= 1'b0;
                r_err       <= (master.b_resp != RESP_OKAY);
            end
`endif
        end
    end

    assign master.aw_id     = '0;
    assign master.aw_addr   = w_axi_addr;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = 3'(LOG_NR_BYTES);
    assign master.aw_burst  = BURST_INCR;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = '0;
    assign master.aw_valid  = r_awvalid;

    assign master.w_data    = r_wdata;
    assign master.w_strb    = r_be;
    assign master.w_last    = 1'b1;
    assign master.w_user    = '0;
    assign master.w_valid   = r_wvalid;

    assign master.b_ready   = r_bready;

    assign master.ar_id     = '0;
    assign master.ar_addr   = w_axi_addr;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = 3'(LOG_NR_BYTES);
    assign master.ar_burst  = BURST_INCR;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = '0;
    assign master.ar_valid  = r_arvalid;

    assign master.r_ready   = r_rready;

    assign gnt_o    = r_gnt;
    assign rvalid_o = r_rvalid;
    assign data_o   = r_rdata;
    assign err_o    = r_err;

endmodule
`default_nettype wire
